// File: rtl/bsort_pkg.sv
// rtl/bsort_pkg.sv - shared state encoding and sort-key selectors for the bubble-sort engine
package bsort_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SORT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    localparam logic [1:0] KEY_FULL = 2'd0;
    localparam logic [1:0] KEY_R    = 2'd1;
    localparam logic [1:0] KEY_G    = 2'd2;
    localparam logic [1:0] KEY_B    = 2'd3;

endpackage

// File: rtl/bsort_cas.sv
// rtl/bsort_cas.sv - combinational key extract, compare and conditional swap of two entries
module bsort_cas
    import bsort_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int IDX_W  = 5
) (
    input  logic [IDX_W-1:0]  a_idx_i,
    input  logic [DATA_W-1:0] a_pix_i,
    input  logic [IDX_W-1:0]  b_idx_i,
    input  logic [DATA_W-1:0] b_pix_i,
    input  logic [1:0]        key_sel_i,
    input  logic              descend_i,
    output logic [IDX_W-1:0]  lo_idx_o,
    output logic [DATA_W-1:0] lo_pix_o,
    output logic [IDX_W-1:0]  hi_idx_o,
    output logic [DATA_W-1:0] hi_pix_o,
    output logic              swap_o
);

    localparam int CH_W = DATA_W / 3;

    // Channel keys are zero-extended so one unsigned compare serves every key width.
    function automatic logic [DATA_W-1:0] key_of(input logic [DATA_W-1:0] pix,
                                                 input logic [1:0] ks);
        logic [DATA_W-1:0] key;
        case (ks)
            KEY_R:   key = DATA_W'(pix[3*CH_W-1 -: CH_W]);
            KEY_G:   key = DATA_W'(pix[2*CH_W-1 -: CH_W]);
            KEY_B:   key = DATA_W'(pix[CH_W-1 -: CH_W]);
            default: key = pix;
        endcase
        return key;
    endfunction

    logic [DATA_W-1:0] key_a;
    logic [DATA_W-1:0] key_b;

    always_comb begin
        key_a  = key_of(a_pix_i, key_sel_i);
        key_b  = key_of(b_pix_i, key_sel_i);
        swap_o = descend_i ? (key_a < key_b) : (key_a > key_b);
        lo_idx_o = swap_o ? b_idx_i : a_idx_i;
        lo_pix_o = swap_o ? b_pix_i : a_pix_i;
        hi_idx_o = swap_o ? a_idx_i : b_idx_i;
        hi_pix_o = swap_o ? a_pix_i : b_pix_i;
    end

endmodule

// File: rtl/bsort_engine.sv
// rtl/bsort_engine.sv - load, in-place bubble sort and handshaked readout of DEPTH pixels
module bsort_engine
    import bsort_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int DATA_W = 24,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [DATA_W-1:0] in,
    input  logic [1:0]        key_sel,
    input  logic              descend,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  image_out_index,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        color_index,
    output logic              done
);

    localparam int              CH_W      = DATA_W / 3;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'(DEPTH - 2);

    function automatic logic [1:0] color_of(input logic [DATA_W-1:0] pix,
                                            input logic [1:0] ks);
        logic [1:0] c;
        case (ks)
            KEY_G:   c = pix[2*CH_W-1 -: 2];
            KEY_B:   c = pix[CH_W-1 -: 2];
            default: c = pix[DATA_W-1 -: 2];
        endcase
        return c;
    endfunction

    // Entry array is intentionally not reset; it is fully rewritten by every load.
    logic [IDX_W-1:0]  idx_mem [DEPTH];
    logic [DATA_W-1:0] pix_mem [DEPTH];

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0]  j_q, j_d;
    logic [IDX_W-1:0]  p_q, p_d;
    logic [IDX_W-1:0]  k_q, k_d;
    logic              swapped_q, swapped_d;
    logic [1:0]        key_sel_q, key_sel_d;
    logic              descend_q, descend_d;
    logic              out_valid_q, out_valid_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [1:0]        out_color_q, out_color_d;

    logic              mem_load_we;
    logic              mem_swap_we;
    logic              done_c;
    logic [IDX_W-1:0]  wr_addr;
    logic [IDX_W-1:0]  j_next;
    logic [IDX_W-1:0]  k_next;
    logic [IDX_W-1:0]  lo_idx, hi_idx;
    logic [DATA_W-1:0] lo_pix, hi_pix;
    logic              cas_swap;

    assign j_next  = j_q + 1'b1;
    assign k_next  = k_q + 1'b1;
    assign wr_addr = (state_q == ST_IDLE) ? '0 : wr_ptr_q;

    bsort_cas #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_cas (
        .a_idx_i   (idx_mem[j_q]),
        .a_pix_i   (pix_mem[j_q]),
        .b_idx_i   (idx_mem[j_next]),
        .b_pix_i   (pix_mem[j_next]),
        .key_sel_i (key_sel_q),
        .descend_i (descend_q),
        .lo_idx_o  (lo_idx),
        .lo_pix_o  (lo_pix),
        .hi_idx_o  (hi_idx),
        .hi_pix_o  (hi_pix),
        .swap_o    (cas_swap)
    );

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        j_d         = j_q;
        p_d         = p_q;
        k_d         = k_q;
        swapped_d   = swapped_q;
        key_sel_d   = key_sel_q;
        descend_d   = descend_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;
        out_color_d = out_color_q;
        mem_load_we = 1'b0;
        mem_swap_we = 1'b0;
        done_c      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    mem_load_we = 1'b1;
                    wr_ptr_d    = IDX_W'(1);
                    key_sel_d   = key_sel;
                    descend_d   = descend;
                    j_d         = '0;
                    p_d         = '0;
                    swapped_d   = 1'b0;
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (load) begin
                    mem_load_we = 1'b1;
                    wr_ptr_d    = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == LAST_IDX) state_d = ST_SORT;
                end
            end
            ST_SORT: begin
                if (cas_swap) begin
                    mem_swap_we = 1'b1;
                    swapped_d   = 1'b1;
                end
                if (j_q == LAST_PASS - p_q) state_d = ST_CHECK;
                else                        j_d     = j_next;
            end
            ST_CHECK: begin
                if (!swapped_q || p_q == LAST_PASS) begin
                    state_d     = ST_OUT;
                    k_d         = '0;
                    out_valid_d = 1'b1;
                    out_idx_d   = idx_mem[0];
                    out_data_d  = pix_mem[0];
                    out_color_d = color_of(pix_mem[0], key_sel_q);
                end else begin
                    p_d       = p_q + 1'b1;
                    j_d       = '0;
                    swapped_d = 1'b0;
                    state_d   = ST_SORT;
                end
            end
            ST_OUT: begin
                if (out_valid_q && out_ready) begin
                    if (k_q == LAST_IDX) begin
                        done_c      = 1'b1;
                        state_d     = ST_IDLE;
                        k_d         = '0;
                        out_valid_d = 1'b0;
                        out_idx_d   = '0;
                        out_data_d  = '0;
                        out_color_d = '0;
                    end else begin
                        k_d         = k_next;
                        out_idx_d   = idx_mem[k_next];
                        out_data_d  = pix_mem[k_next];
                        out_color_d = color_of(pix_mem[k_next], key_sel_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            j_q         <= '0;
            p_q         <= '0;
            k_q         <= '0;
            swapped_q   <= 1'b0;
            key_sel_q   <= KEY_FULL;
            descend_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
            out_color_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            j_q         <= j_d;
            p_q         <= p_d;
            k_q         <= k_d;
            swapped_q   <= swapped_d;
            key_sel_q   <= key_sel_d;
            descend_q   <= descend_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
            out_color_q <= out_color_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_load_we) begin
            idx_mem[wr_addr] <= wr_addr;
            pix_mem[wr_addr] <= in;
        end else if (mem_swap_we) begin
            idx_mem[j_q]    <= lo_idx;
            pix_mem[j_q]    <= lo_pix;
            idx_mem[j_next] <= hi_idx;
            pix_mem[j_next] <= hi_pix;
        end
    end

    assign busy            = (state_q == ST_SORT) || (state_q == ST_CHECK) || (state_q == ST_OUT);
    assign out_valid       = out_valid_q;
    assign image_out_index = out_idx_q;
    assign out_data        = out_data_q;
    assign color_index     = out_color_q;
    assign done            = done_c;

endmodule

// File: tb/tb_bsort_engine.sv
// tb/tb_bsort_engine.sv - scoreboard bench for bsort_engine at DEPTH=4 and DEPTH=32
module tb_bsort_engine;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ld = 1'b0, rdy = 1'b0, sel = 1'b0;
    logic [23:0] in_w = '0;
    logic [1:0]  ks_w = '0;
    logic        desc_w = 1'b0;

    logic        load4, load32, rdy4, rdy32;
    logic        busy4, ov4, done4, busy32, ov32, done32;
    logic [1:0]  idx4, col4, col32;
    logic [4:0]  idx32;
    logic [23:0] data4, data32;

    logic        m_busy, m_ov, m_done;
    logic [4:0]  m_idx;
    logic [23:0] m_data;
    logic [1:0]  m_col;

    typedef struct {
        logic [4:0]  idx;
        logic [23:0] pix;
    } ent_t;

    ent_t        exp_q[$];
    logic [1:0]  cur_ks;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    assign load4  = ld & ~sel;
    assign load32 = ld & sel;
    assign rdy4   = rdy & ~sel;
    assign rdy32  = rdy & sel;

    bsort_engine #(.DEPTH(4), .DATA_W(24)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .load(load4), .in(in_w), .key_sel(ks_w),
        .descend(desc_w), .busy(busy4), .out_valid(ov4), .out_ready(rdy4),
        .image_out_index(idx4), .out_data(data4), .color_index(col4), .done(done4)
    );

    bsort_engine #(.DEPTH(32), .DATA_W(24)) u_dut32 (
        .clk(clk), .reset_n(reset_n), .load(load32), .in(in_w), .key_sel(ks_w),
        .descend(desc_w), .busy(busy32), .out_valid(ov32), .out_ready(rdy32),
        .image_out_index(idx32), .out_data(data32), .color_index(col32), .done(done32)
    );

    always_comb begin
        m_busy = sel ? busy32 : busy4;
        m_ov   = sel ? ov32   : ov4;
        m_done = sel ? done32 : done4;
        m_idx  = sel ? idx32  : {3'b000, idx4};
        m_data = sel ? data32 : data4;
        m_col  = sel ? col32  : col4;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] key_of(input logic [23:0] p, input logic [1:0] ks);
        case (ks)
            2'd1:    return {16'h0, p[23:16]};
            2'd2:    return {16'h0, p[15:8]};
            2'd3:    return {16'h0, p[7:0]};
            default: return p;
        endcase
    endfunction

    function automatic logic [1:0] color_of(input logic [23:0] p, input logic [1:0] ks);
        case (ks)
            2'd2:    return p[15:14];
            2'd3:    return p[7:6];
            default: return p[23:22];
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Stable insertion model builds the expected output order; later loads drive a different key to prove latching.
    task automatic load_run(input logic s, input logic [23:0] pix[$], input logic [1:0] ks,
                            input logic d, input bit gaps);
        ent_t r[$];
        ent_t e;
        int   pos;
        sel    = s;
        cur_ks = ks;
        for (int i = 0; i < pix.size(); i++) begin
            e.idx = 5'(i);
            e.pix = pix[i];
            pos   = r.size();
            while (pos > 0 && (d ? (key_of(r[pos-1].pix, ks) < key_of(e.pix, ks))
                                 : (key_of(r[pos-1].pix, ks) > key_of(e.pix, ks))))
                pos--;
            r.insert(pos, e);
        end
        exp_q.delete();
        foreach (r[i]) exp_q.push_back(r[i]);
        for (int i = 0; i < pix.size(); i++) begin
            if (gaps && i == 2) begin
                ld = 1'b0;
                tick();
            end
            ld     = 1'b1;
            in_w   = pix[i];
            ks_w   = (i == 0) ? ks : ~ks;
            desc_w = (i == 0) ? d : ~d;
            tick();
        end
        ld = 1'b0;
    endtask

    task automatic wait_valid(input bit junk, output int lat);
        lat = 0;
        while (!m_ov && lat < 3000) begin
            if (m_busy) lat++;
            if (junk) begin
                ld = 1'b1; in_w = $urandom; ks_w = 2'($urandom); desc_w = 1'($urandom);
            end
            tick();
        end
        check_val("sort_timeout", {31'd0, m_ov}, 32'd1);
    endtask

    task automatic collect(input bit rand_rdy, input bit junk, output int cycles);
        int   n;
        int   got;
        ent_t e;
        n = exp_q.size();
        got = 0;
        cycles = 0;
        while (got < n && cycles < 5000) begin
            rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (junk) begin
                ld = 1'b1; in_w = $urandom; ks_w = 2'($urandom); desc_w = 1'($urandom);
            end
            #1;
            e = exp_q[0];
            check_val("out_valid", {31'd0, m_ov}, 32'd1);
            check_val("out_index", {27'd0, m_idx}, {27'd0, e.idx});
            check_val("out_data", {8'd0, m_data}, {8'd0, e.pix});
            check_val("color_index", {30'd0, m_col}, {30'd0, color_of(e.pix, cur_ks)});
            if (rdy) begin
                check_val("done", {31'd0, m_done}, (got == n - 1) ? 32'd1 : 32'd0);
                void'(exp_q.pop_front());
                got++;
                if (got == n) ld = 1'b0;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        rdy = 1'b0;
        ld  = 1'b0;
        check_val("words_accepted", got, n);
        check_val("post_valid", {31'd0, m_ov}, 32'd0);
        check_val("post_busy", {31'd0, m_busy}, 32'd0);
        check_val("post_zero", {m_done, m_col, m_idx, m_data}, 32'd0);
    endtask

    logic [23:0] pix[$];
    int          lat, cyc;

    initial begin
        reset_n = 1'b0;
        tick();
        tick();
        sel = 1'b0;
        check_val("rst4_outputs", {m_busy, m_ov, m_done, m_col, m_idx, m_data}, 32'd0);
        sel = 1'b1;
        #1;
        check_val("rst32_outputs", {m_busy, m_ov, m_done, m_col, m_idx, m_data}, 32'd0);
        reset_n = 1'b1;
        tick();

        // stable tie: 30,10,20,10 ascending full key, with a load stall
        pix = '{24'd30, 24'd10, 24'd20, 24'd10};
        load_run(1'b0, pix, 2'd0, 1'b0, 1'b1);
        check_val("tie_first_idx", {27'd0, exp_q[0].idx}, 32'd1);
        wait_valid(1'b0, lat);
        collect(1'b0, 1'b0, cyc);
        check_val("d4_one_per_cycle", cyc, 4);

        pix = '{24'd1, 24'd2, 24'd3, 24'd4};
        load_run(1'b0, pix, 2'd0, 1'b0, 1'b0);
        wait_valid(1'b0, lat);
        check_val("presorted_latency", lat, 4);
        collect(1'b0, 1'b0, cyc);

        pix = '{24'd4, 24'd3, 24'd2, 24'd1};
        load_run(1'b0, pix, 2'd0, 1'b0, 1'b0);
        wait_valid(1'b0, lat);
        check_val("worst_latency", lat, 9);
        collect(1'b0, 1'b0, cyc);

        // DEPTH=32 descending on G, G drawn from few values to force ties
        pix.delete();
        for (int i = 0; i < 32; i++)
            pix.push_back({8'($urandom), 2'($urandom_range(0, 3)), 6'd0, 8'($urandom)});
        load_run(1'b1, pix, 2'd2, 1'b1, 1'b0);
        wait_valid(1'b0, lat);
        collect(1'b0, 1'b0, cyc);
        check_val("d32_one_per_cycle", cyc, 32);

        pix.delete();
        for (int i = 0; i < 32; i++) pix.push_back(24'($urandom));
        load_run(1'b1, pix, 2'd1, 1'b0, 1'b1);
        wait_valid(1'b0, lat);
        collect(1'b1, 1'b0, cyc);

        // reset mid-sort, then a fresh sort must start from index 0
        pix.delete();
        for (int i = 0; i < 32; i++) pix.push_back(24'($urandom));
        load_run(1'b1, pix, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        check_val("mid_sort_busy", {31'd0, m_busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_val("async_rst_outputs", {m_busy, m_ov, m_done, m_col, m_idx, m_data}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        pix.delete();
        for (int i = 0; i < 32; i++) pix.push_back(24'($urandom));
        load_run(1'b1, pix, 2'd3, 1'b0, 1'b0);
        wait_valid(1'b0, lat);
        collect(1'b1, 1'b0, cyc);

        // load held high with junk through SORT and OUT
        pix = '{24'h00_00_05, 24'h00_00_09, 24'h00_00_C1, 24'h00_00_07};
        load_run(1'b0, pix, 2'd3, 1'b1, 1'b0);
        wait_valid(1'b1, lat);
        collect(1'b1, 1'b1, cyc);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
